// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output-port arbiter: lock FSM states and
// the index wrap helper used by the rotating priority pointer.
package noc_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_t;

    // Wraps at num-1, so the pointer stays below num for non-power-of-two counts.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned num);
        return (idx >= num - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_lock_if.sv
// Request/grant bundle between the requesters and one arbiter output port.
interface rr_arbiter_lock_if #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOG2_NUM_REQ = 2
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      req_last;
    logic                    gnt_ready;
    logic [NUM_REQ-1:0]      gnt_dec;
    logic [LOG2_NUM_REQ-1:0] gnt_enc;
    logic                    gnt_valid;
    logic                    locked;

    modport master (
        output req, req_last, gnt_ready,
        input  gnt_dec, gnt_enc, gnt_valid, locked
    );

    modport slave (
        input  req, req_last, gnt_ready,
        output gnt_dec, gnt_enc, gnt_valid, locked
    );
endinterface

// File: rtl/pri_enc_lsb.sv
// Combinational lowest-set-bit finder: one-hot, encoded index and found flag.
module pri_enc_lsb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] vec,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && vec[i]) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_lock.sv
// Round-robin arbiter with rotating priority that holds the grant on one
// requester from head to tail flit so packets are never interleaved.
module rr_arbiter_lock
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOG2_NUM_REQ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter_lock_if.slave bus
);
    typedef logic [LOG2_NUM_REQ-1:0] idx_t;

    arb_state_t         state;
    idx_t               ptr;
    idx_t               lock_idx;
    logic [NUM_REQ-1:0] ptr_mask;
    logic [NUM_REQ-1:0] lock_oh;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] m_oh;
    logic [NUM_REQ-1:0] r_oh;
    idx_t               m_idx;
    idx_t               r_idx;
    logic               m_found;
    logic               r_found;
    logic               xfer;
    logic               last_win;

    always_comb begin
        ptr_mask = '0;
        lock_oh  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ptr_mask[i] = (i >= 32'(ptr));
            lock_oh[i]  = (i == 32'(lock_idx));
        end
    end

    assign masked = bus.req & ptr_mask;

    pri_enc_lsb #(.NUM_REQ(NUM_REQ), .IDX_W(LOG2_NUM_REQ)) u_masked (
        .vec    (masked),
        .onehot (m_oh),
        .idx    (m_idx),
        .found  (m_found)
    );

    pri_enc_lsb #(.NUM_REQ(NUM_REQ), .IDX_W(LOG2_NUM_REQ)) u_unmasked (
        .vec    (bus.req),
        .onehot (r_oh),
        .idx    (r_idx),
        .found  (r_found)
    );

    // In LOCK other requesters are ignored; a bubble drops the grant but keeps the lock.
    always_comb begin
        bus.gnt_dec   = '0;
        bus.gnt_enc   = '0;
        bus.gnt_valid = 1'b0;
        bus.locked    = (state == ARB_LOCK);
        if (state == ARB_LOCK) begin
            bus.gnt_dec   = lock_oh & bus.req;
            bus.gnt_valid = |(lock_oh & bus.req);
            bus.gnt_enc   = bus.gnt_valid ? lock_idx : '0;
        end else begin
            bus.gnt_dec   = m_found ? m_oh : r_oh;
            bus.gnt_enc   = m_found ? m_idx : r_idx;
            bus.gnt_valid = r_found;
        end
    end

    assign xfer     = bus.gnt_valid & bus.gnt_ready;
    assign last_win = |(bus.gnt_dec & bus.req_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            lock_idx <= '0;
        end else if (xfer) begin
            case (state)
                ARB_IDLE: begin
                    if (last_win) begin
                        ptr <= idx_t'(wrap_inc(32'(bus.gnt_enc), NUM_REQ));
                    end else begin
                        state    <= ARB_LOCK;
                        lock_idx <= bus.gnt_enc;
                    end
                end
                ARB_LOCK: begin
                    if (last_win) begin
                        state <= ARB_IDLE;
                        ptr   <= idx_t'(wrap_inc(32'(lock_idx), NUM_REQ));
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Scoreboard bench for rr_arbiter_lock with a 4-requester and a 3-requester instance.
module tb_rr_arbiter_lock;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n3 = 1'b0;
    always #5 clk = ~clk;

    rr_arbiter_lock_if #(.NUM_REQ(4), .LOG2_NUM_REQ(2)) bus4 ();
    rr_arbiter_lock_if #(.NUM_REQ(3), .LOG2_NUM_REQ(2)) bus3 ();

    rr_arbiter_lock #(.NUM_REQ(4), .LOG2_NUM_REQ(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    rr_arbiter_lock #(.NUM_REQ(3), .LOG2_NUM_REQ(2)) dut3 (
        .clk   (clk),
        .rst_n (rst_n3),
        .bus   (bus3)
    );

    typedef struct {
        string      name;
        logic       valid;
        logic [1:0] enc;
        logic       locked;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    task automatic step4(input string name, input logic rs, input logic [3:0] r, input logic [3:0] l,
                         input logic rdy, input logic ev, input logic [1:0] ee, input logic el);
        @(posedge clk);
        #1;
        rst_n          = rs;
        bus4.req       = r;
        bus4.req_last  = l;
        bus4.gnt_ready = rdy;
        q4.push_back('{name, ev, ee, el});
    endtask

    task automatic step3(input string name, input logic rs, input logic [2:0] r, input logic [2:0] l,
                         input logic rdy, input logic ev, input logic [1:0] ee, input logic el);
        @(posedge clk);
        #1;
        rst_n3         = rs;
        bus3.req       = r;
        bus3.req_last  = l;
        bus3.gnt_ready = rdy;
        q3.push_back('{name, ev, ee, el});
    endtask

    function automatic void chk(input string name, input string field, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h @%0t", name, field, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            chk(e.name, "gnt_valid", 32'(bus4.gnt_valid), 32'(e.valid));
            chk(e.name, "gnt_enc",   32'(bus4.gnt_enc),   32'(e.enc));
            chk(e.name, "gnt_dec",   32'(bus4.gnt_dec),   e.valid ? (32'd1 << e.enc) : 32'd0);
            chk(e.name, "locked",    32'(bus4.locked),    32'(e.locked));
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            chk(e.name, "gnt_valid", 32'(bus3.gnt_valid), 32'(e.valid));
            chk(e.name, "gnt_enc",   32'(bus3.gnt_enc),   32'(e.enc));
            chk(e.name, "gnt_dec",   32'(bus3.gnt_dec),   e.valid ? (32'd1 << e.enc) : 32'd0);
            chk(e.name, "locked",    32'(bus3.locked),    32'(e.locked));
        end
        if (done) begin
            chk("drain", "pending", 32'(q4.size() + q3.size()), 32'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        bus4.req = '0; bus4.req_last = '0; bus4.gnt_ready = 1'b0;
        bus3.req = '0; bus3.req_last = '0; bus3.gnt_ready = 1'b0;

        // Held in reset: grant is lowest set bit, never locked, no state change.
        step4("rst_lowest", 0, 4'b0110, 4'b0000, 1, 1, 2'd1, 0);
        step4("rst_none",   0, 4'b0000, 4'b0000, 1, 0, 2'd0, 0);

        // All requesting single flits: 0,1,2,3,0,1,2,3.
        step4("rr_all0", 1, 4'b1111, 4'b1111, 1, 1, 2'd0, 0);
        step4("rr_all1", 1, 4'b1111, 4'b1111, 1, 1, 2'd1, 0);
        step4("rr_all2", 1, 4'b1111, 4'b1111, 1, 1, 2'd2, 0);
        step4("rr_all3", 1, 4'b1111, 4'b1111, 1, 1, 2'd3, 0);
        step4("rr_all4", 1, 4'b1111, 4'b1111, 1, 1, 2'd0, 0);
        step4("rr_all5", 1, 4'b1111, 4'b1111, 1, 1, 2'd1, 0);
        step4("rr_all6", 1, 4'b1111, 4'b1111, 1, 1, 2'd2, 0);
        step4("rr_all7", 1, 4'b1111, 4'b1111, 1, 1, 2'd3, 0);

        // Sparse requests 1 and 3 alternate across the wrap.
        step4("alt0", 1, 4'b1010, 4'b1111, 1, 1, 2'd1, 0);
        step4("alt1", 1, 4'b1010, 4'b1111, 1, 1, 2'd3, 0);
        step4("alt2", 1, 4'b1010, 4'b1111, 1, 1, 2'd1, 0);
        step4("alt3", 1, 4'b1010, 4'b1111, 1, 1, 2'd3, 0);

        // Move ptr to 2, then a 3-flit packet on 2 against a competing 0.
        step4("pre1",  1, 4'b0010, 4'b0010, 1, 1, 2'd1, 0);
        step4("pkt_h", 1, 4'b0101, 4'b0000, 1, 1, 2'd2, 0);
        step4("pkt_b", 1, 4'b0101, 4'b0000, 1, 1, 2'd2, 1);
        step4("pkt_t", 1, 4'b0101, 4'b0100, 1, 1, 2'd2, 1);
        step4("ptr3",  1, 4'b1001, 4'b1001, 1, 1, 2'd3, 0);
        step4("after", 1, 4'b0001, 4'b0001, 1, 1, 2'd0, 0);

        // ptr=1: lock on 1, then a 2-cycle bubble while 0 requests.
        step4("lk1_h",  1, 4'b0011, 4'b0000, 1, 1, 2'd1, 0);
        step4("bub0",   1, 4'b0001, 4'b0000, 1, 0, 2'd0, 1);
        step4("bub1",   1, 4'b0001, 4'b0000, 1, 0, 2'd0, 1);
        step4("lk1_b",  1, 4'b0011, 4'b0000, 1, 1, 2'd1, 1);

        // Back-pressure with tail pending, then release.
        step4("stall0", 1, 4'b0011, 4'b0010, 0, 1, 2'd1, 1);
        step4("stall1", 1, 4'b0011, 4'b0010, 0, 1, 2'd1, 1);
        step4("stall2", 1, 4'b0011, 4'b0010, 0, 1, 2'd1, 1);
        step4("lk1_t",  1, 4'b0011, 4'b0010, 1, 1, 2'd1, 1);
        step4("unlock", 1, 4'b0011, 4'b0011, 1, 1, 2'd0, 0);
        step4("idle0",  1, 4'b0000, 4'b0000, 1, 0, 2'd0, 0);

        // Three requesters: wrap at 2 with no stall.
        step3("n3_0", 1, 3'b111, 3'b111, 1, 1, 2'd0, 0);
        step3("n3_1", 1, 3'b111, 3'b111, 1, 1, 2'd1, 0);
        step3("n3_2", 1, 3'b111, 3'b111, 1, 1, 2'd2, 0);
        step3("n3_3", 1, 3'b111, 3'b111, 1, 1, 2'd0, 0);
        step3("n3_lh", 1, 3'b110, 3'b000, 1, 1, 2'd1, 0);
        step3("n3_lb", 1, 3'b110, 3'b000, 1, 1, 2'd1, 1);
        // Reset mid-packet takes effect before the next clock edge.
        step3("n3_rst", 0, 3'b111, 3'b000, 1, 1, 2'd0, 0);
        step3("n3_rel", 1, 3'b110, 3'b110, 1, 1, 2'd1, 0);
        step3("n3_nxt", 1, 3'b101, 3'b101, 1, 1, 2'd2, 0);

        done = 1'b1;
    end
endmodule
